// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
// Holds the controller state encoding, the default fill word and a clog2 helper.
package imem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } imem_state_e;

  // MIPS "sll $0,$0,0" encodes as all zeros.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Single-clock DEPTH x DATA_W RAM with one synchronous read port and one write port.
// A read and write to the same index in one cycle returns the old contents.
module imem_ram_1r1w
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                IDX_W     = clog2(DEPTH),
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Only the output register is reset; the array itself is filled by the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= RESET_VAL;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the single-cycle MIPS core: registered fetch port with fault
// detection, streaming load port with auto-incrementing pointer, NOP clear sweep after reset.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy
);

  localparam int IDX_W = clog2(DEPTH);

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q;
  logic [IDX_W-1:0] wr_ptr_q;
  logic             fetch_valid_q;
  logic             fetch_fault_q;

  logic             fetch_go;
  logic             fault_now;
  logic             load_go;
  logic             start_go;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] load_idx;
  logic             ram_we;
  logic [IDX_W-1:0] ram_widx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic             load_addr_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        fetch_ready = 1'b1;
        load_ready  = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Handshakes: a fetch is taken on a cycle with fetch_req & fetch_ready, a load word on
  // load_valid & load_ready; neither ready depends on the request, and both drop in CLEAR.
  assign fetch_go  = fetch_req & fetch_ready;
  assign fault_now = (fetch_addr[1:0] != 2'b00) | (|(fetch_addr >> (IDX_W + 2)));

  assign load_go   = load_valid & load_ready;
  assign start_go  = load_start & load_ready;
  assign start_idx = load_addr[IDX_W+1:2];
  // A start pulse with a same-cycle word writes the word at the new start index.
  assign load_idx  = start_go ? start_idx : wr_ptr_q;

  assign load_addr_unused = ^{load_addr[ADDR_W-1:IDX_W+2], load_addr[1:0]};

  assign ram_we    = ~reset & (busy | load_go);
  assign ram_widx  = busy ? clr_idx_q : load_idx;
  assign ram_wdata = busy ? NOP_WORD : load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx_q     <= '0;
      wr_ptr_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      if (busy) begin
        clr_idx_q <= clr_idx_q + IDX_W'(1);
      end
      if (load_go) begin
        wr_ptr_q <= load_idx + IDX_W'(1);
      end else if (start_go) begin
        wr_ptr_q <= start_idx;
      end
      fetch_valid_q <= fetch_go;
      if (fetch_go) begin
        fetch_fault_q <= fault_now;
      end
    end
  end

  imem_ram_1r1w #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .RESET_VAL (NOP_WORD)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (fetch_go & ~fault_now),
    .rd_idx  (fetch_addr[IDX_W+1:2]),
    .rd_data (ram_rdata),
    .wr_en   (ram_we),
    .wr_idx  (ram_widx),
    .wr_data (ram_wdata)
  );

  // A faulted fetch leaves the RAM output untouched, so the NOP is substituted here.
  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_data  = fetch_fault_q ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed scenarios plus randomized traffic, all checked
// against an array-based model of the memory, pointer and clear countdown.
module tb_instr_mem_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic        load_start = 1'b0;
  logic [31:0] load_addr = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        busy;

  always #5 clk = ~clk;

  instr_mem_ctrl #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_addr   (load_addr),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .busy        (busy)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_mem [DEPTH];
  int          exp_ptr = 0;
  int          clear_left = DEPTH;
  logic [32:0] exp_q [$];
  logic [31:0] last_data = '0;
  logic        last_fault = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then check the outputs.
  task automatic tick();
    logic        acc;
    logic        flt;
    logic [32:0] e;
    acc = 1'b0;
    if (reset) begin
      clear_left = DEPTH;
      exp_ptr    = 0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
      exp_q.delete();
      last_data  = 32'h0;
      last_fault = 1'b0;
    end else if (clear_left == 0) begin
      if (fetch_req) begin
        acc = 1'b1;
        flt = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= 32'(DEPTH * 4));
        exp_q.push_back({flt, flt ? 32'h0 : exp_mem[fetch_addr[7:2]]});
      end
      if (load_start) exp_ptr = int'(load_addr[7:2]);
      if (load_valid) begin
        exp_mem[exp_ptr] = load_data;
        exp_ptr = (exp_ptr + 1) % DEPTH;
      end
    end else begin
      clear_left--;
    end
    @(posedge clk);
    #1;
    check("busy", busy, clear_left > 0);
    check("fetch_ready", fetch_ready, clear_left == 0);
    check("load_ready", load_ready, clear_left == 0);
    check("fetch_valid", fetch_valid, acc);
    if (acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_fault = e[32];
      last_data  = e[31:0];
    end
    check("fetch_data", fetch_data, last_data);
    check("fetch_fault", fetch_fault, last_fault);
  endtask

  task automatic idle();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] data);
    load_valid = 1'b1;
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    // Reset for two cycles, then the sweep must hold busy for DEPTH cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    check("ready_after_clear", fetch_ready, 1'b1);
    do_fetch(32'h0);
    check("clear_f0", fetch_data, 32'h0);
    do_fetch(32'h4);
    do_fetch(32'hFC);
    check("clear_ffc", fetch_data, 32'h0);

    // Program load and fetch.
    load_start = 1'b1;
    load_addr  = 32'h0;
    tick();
    load_start = 1'b0;
    load_word(32'h2008_0005);
    load_word(32'h2009_0003);
    load_word(32'h0109_5020);
    do_fetch(32'h4);
    check("load_f4", fetch_data, 32'h2009_0003);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    tick();
    check("b2b_f0", fetch_data, 32'h2008_0005);
    fetch_addr = 32'h8;
    tick();
    check("b2b_f8", fetch_data, 32'h0109_5020);
    fetch_req  = 1'b0;
    tick();

    // Faults.
    do_fetch(32'h6);
    check("fault_6", fetch_fault, 1'b1);
    do_fetch(32'h100);
    check("fault_100", fetch_fault, 1'b1);
    do_fetch(32'hFFFF_FFFC);
    check("fault_top", fetch_fault, 1'b1);
    do_fetch(32'h0);
    check("nofault_0", fetch_fault, 1'b0);

    // Pointer wrap with a same-cycle start and word.
    load_start = 1'b1;
    load_addr  = 32'hFC;
    load_valid = 1'b1;
    load_data  = 32'hAAAA_0001;
    tick();
    load_start = 1'b0;
    load_word(32'hAAAA_0002);
    do_fetch(32'hFC);
    check("wrap_ffc", fetch_data, 32'hAAAA_0001);
    do_fetch(32'h0);
    check("wrap_f0", fetch_data, 32'hAAAA_0002);

    // Read-before-write on index 2.
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    load_start = 1'b1;
    load_addr  = 32'h8;
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    tick();
    idle();
    check("rbw_old", fetch_data, 32'h0109_5020);
    do_fetch(32'h8);
    check("rbw_new", fetch_data, 32'hDEAD_BEEF);

    // Reset in the middle of a load stream with a fetch requested.
    load_start = 1'b1;
    load_addr  = 32'h10;
    load_valid = 1'b1;
    load_data  = 32'h1111_2222;
    tick();
    load_start = 1'b0;
    load_data  = 32'h3333_4444;
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    reset      = 1'b1;
    tick();
    check("rst_drop", fetch_valid, 1'b0);
    reset = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) tick();
    do_fetch(32'h10);
    check("rst_f10", fetch_data, 32'h0);
    do_fetch(32'h8);
    do_fetch(32'h0);
    check("rst_f0", fetch_data, 32'h0);

    // Randomized traffic, with one reset part-way through.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      fetch_req = 1'($urandom_range(0, 1));
      if (r < 7) fetch_addr = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 7) fetch_addr = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else fetch_addr = $urandom;
      load_start = ($urandom_range(0, 7) == 0);
      load_addr  = $urandom;
      load_valid = 1'($urandom_range(0, 1));
      load_data  = $urandom;
      reset      = (i == 300);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
